// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - exception/return sequencer for the 5-stage, 2-slot pipeline
//
// Detects EX-stage overflow and ID-stage undefined opcodes, squashes younger work,
// redirects fetch to the handler vector and returns to EPC on ERET. A fault taken
// while already in the handler, or a handler that never returns (watchdog), parks
// the pipeline in a sticky HALT that only reset leaves.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   ovf_alu, ovf_mem      EX-stage overflow sources
//   undef1, undef2, eret  ID-stage decode events (ignored while stall_in)
//   stall_in              hazard-unit stall of ID
//   ex_pc, id_pc          PCs of the EX and ID instructions
//   flush_if_id, kill_id, kill_ex  same-cycle squash controls
//   pc_sel, pc_vec        fetch redirect: 00 normal, 01 vector, 10 EPC, 11 hold
//   epc_q, cause_q        exception PC and cause registers
//   in_handler, halted    state indicators
//   exc_count             saturating count of accepted exceptions
module exception_sequencer #(
  parameter logic [31:0] VECTOR  = 32'd60,
  parameter int          CNT_W   = 8,
  parameter int          WDT_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ovf_alu,
  input  logic             ovf_mem,
  input  logic             undef1,
  input  logic             undef2,
  input  logic             eret,
  input  logic             stall_in,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      id_pc,
  output logic             flush_if_id,
  output logic             kill_id,
  output logic             kill_ex,
  output logic [1:0]       pc_sel,
  output logic [31:0]      pc_vec,
  output logic [31:0]      epc_q,
  output logic [1:0]       cause_q,
  output logic             in_handler,
  output logic             halted,
  output logic [CNT_W-1:0] exc_count
);

  localparam int WDT_W = (WDT_MAX > 1) ? $clog2(WDT_MAX + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HANDLER = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WDT_W-1:0] wdt_q;

  logic       ovf;
  logic       u1;
  logic       u2;
  logic       er;
  logic       fault;
  logic       wdt_fire;
  logic [1:0] fault_cause;

  // ID-stage events only count when the instruction actually leaves ID.
  assign ovf   = ovf_alu | ovf_mem;
  assign u1    = undef1 & ~stall_in;
  assign u2    = undef2 & ~stall_in;
  assign er    = eret & ~stall_in;
  assign fault = ovf | u1 | u2;

  // EX is older than ID, so overflow outranks either undefined slot.
  always_comb begin
    fault_cause = 2'b11;
    if (ovf)     fault_cause = 2'b01;
    else if (u1) fault_cause = 2'b10;
  end

  // A returning handler beats the watchdog; a double fault is reported as such.
  assign wdt_fire = (WDT_MAX != 0) && (state_q == S_HANDLER) &&
                    (wdt_q == WDT_W'(WDT_MAX)) && !er && !fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (fault) state_d = S_HANDLER;
      S_HANDLER: begin
        if (fault || wdt_fire) state_d = S_HALT;
        else if (er)           state_d = S_IDLE;
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    flush_if_id = 1'b0;
    kill_id     = 1'b0;
    kill_ex     = 1'b0;
    pc_sel      = 2'b00;
    pc_vec      = VECTOR;
    case (state_q)
      S_IDLE: begin
        if (fault) begin
          flush_if_id = 1'b1;
          kill_id     = 1'b1;
          kill_ex     = ovf;  // an ID fault lets the older EX instruction complete
          pc_sel      = 2'b01;
        end
      end
      S_HANDLER: begin
        if (fault || wdt_fire) begin
          flush_if_id = 1'b1;
          kill_id     = 1'b1;
          kill_ex     = 1'b1;
          pc_sel      = 2'b11;
        end else if (er) begin
          flush_if_id = 1'b1;
          pc_sel      = 2'b10;
          pc_vec      = epc_q;
        end
      end
      S_HALT: begin
        flush_if_id = 1'b1;
        kill_id     = 1'b1;
        kill_ex     = 1'b1;
        pc_sel      = 2'b11;
      end
      default: ;
    endcase
  end

  assign in_handler = (state_q == S_HANDLER);
  assign halted     = (state_q == S_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_q     <= '0;
      cause_q   <= '0;
      exc_count <= '0;
      wdt_q     <= '0;
    end else begin
      // EPC is captured only on the first fault; a double fault keeps the
      // original return address for post-mortem.
      if (state_q == S_IDLE && fault) begin
        epc_q   <= ovf ? ex_pc : id_pc;
        cause_q <= fault_cause;
      end else if (state_q == S_HANDLER && fault) begin
        cause_q <= fault_cause;
      end else if (wdt_fire) begin
        cause_q <= 2'b00;
      end

      if (fault && state_q != S_HALT && exc_count != '1) begin
        exc_count <= exc_count + 1'b1;
      end

      // Held at zero outside HANDLER, so it is already clear on entry.
      if (state_q == S_HANDLER && WDT_MAX != 0) wdt_q <= wdt_q + 1'b1;
      else                                      wdt_q <= '0;
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - scoreboard bench for exception_sequencer
module tb_exception_sequencer;

  typedef struct packed {
    logic        rst;
    logic        oa;
    logic        om;
    logic        u1;
    logic        u2;
    logic        er;
    logic        st;
    logic [31:0] ex_pc;
    logic [31:0] id_pc;
  } stim_t;

  typedef struct packed {
    logic        fl;
    logic        kid;
    logic        kex;
    logic [1:0]  sel;
    logic [31:0] vec;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        inh;
    logic        hlt;
    logic [1:0]  cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ovf_alu = 1'b0, ovf_mem = 1'b0, undef1 = 1'b0, undef2 = 1'b0;
  logic        eret = 1'b0, stall_in = 1'b0;
  logic [31:0] ex_pc = '0, id_pc = '0;
  logic        flush_if_id, kill_id, kill_ex, in_handler, halted;
  logic [1:0]  pc_sel, cause_q, exc_count;
  logic [31:0] pc_vec, epc_q;
  obs_t        obs;

  int checks = 0;
  int passes = 0;

  stim_t sq[$];
  obs_t  eq[$];
  string nq[$];

  always #5 clk = ~clk;

  exception_sequencer #(.VECTOR(32'd60), .CNT_W(2), .WDT_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .ovf_alu(ovf_alu), .ovf_mem(ovf_mem), .undef1(undef1), .undef2(undef2),
    .eret(eret), .stall_in(stall_in), .ex_pc(ex_pc), .id_pc(id_pc),
    .flush_if_id(flush_if_id), .kill_id(kill_id), .kill_ex(kill_ex),
    .pc_sel(pc_sel), .pc_vec(pc_vec), .epc_q(epc_q), .cause_q(cause_q),
    .in_handler(in_handler), .halted(halted), .exc_count(exc_count)
  );

  assign obs = {flush_if_id, kill_id, kill_ex, pc_sel, pc_vec, epc_q, cause_q,
                in_handler, halted, exc_count};

  function automatic stim_t s(logic rst, logic oa, logic om, logic u1, logic u2,
                              logic er, logic st, logic [31:0] xp, logic [31:0] ip);
    return '{rst, oa, om, u1, u2, er, st, xp, ip};
  endfunction

  function automatic obs_t o(logic fl, logic kid, logic kex, logic [1:0] sel,
                             logic [31:0] vec, logic [31:0] epc, logic [1:0] cause,
                             logic inh, logic hlt, logic [1:0] cnt);
    return '{fl, kid, kex, sel, vec, epc, cause, inh, hlt, cnt};
  endfunction

  task automatic push(input string n, input stim_t st, input obs_t ex);
    sq.push_back(st);
    eq.push_back(ex);
    nq.push_back(n);
  endtask

  // Drive one cycle's inputs just after the falling edge and let them settle.
  task automatic apply(input stim_t st);
    @(negedge clk);
    reset    = st.rst;
    ovf_alu  = st.oa;
    ovf_mem  = st.om;
    undef1   = st.u1;
    undef2   = st.u2;
    eret     = st.er;
    stall_in = st.st;
    ex_pc    = st.ex_pc;
    id_pc    = st.id_pc;
    #1;
  endtask

  localparam logic [31:0] V = 32'd60;

  task automatic test_reset;
    obs_t e; string n;
    push("rst_assert",      s(0,0,0,0,0,0,0,0,0),       o(0,0,0,0,V,0,0,0,0,0));
    push("rst_idle",        s(1,0,0,0,0,0,0,0,0),       o(0,0,0,0,V,0,0,0,0,0));
    push("rst_enter",       s(1,1,0,0,0,0,0,32'h44,0),  o(1,1,1,1,V,0,0,0,0,0));
    push("rst_in_handler",  s(1,0,0,0,0,0,0,0,0),       o(0,0,0,0,V,32'h44,1,1,0,1));
    push("rst_mid_handler", s(0,0,0,0,0,0,0,0,0),       o(0,0,0,0,V,0,0,0,0,0));
    push("rst_release",     s(1,0,0,0,0,0,0,0,0),       o(0,0,0,0,V,0,0,0,0,0));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      e = eq.pop_front(); n = nq.pop_front(); checks++;
      if (obs !== e) $display("FAIL %s: got %h expected %h", n, obs, e);
      else passes++;
    end
  endtask

  task automatic test_ovf;
    obs_t e; string n;
    push("ovf_enter",        s(1,1,0,1,0,0,0,32'h24,32'h99), o(1,1,1,1,V,0,0,0,0,0));
    push("ovf_handler",      s(1,0,0,0,0,0,0,0,0),           o(0,0,0,0,V,32'h24,1,1,0,1));
    push("ovf_eret_stalled", s(1,0,0,0,0,1,1,0,0),           o(0,0,0,0,V,32'h24,1,1,0,1));
    push("ovf_eret",         s(1,0,0,0,0,1,0,0,0),           o(1,0,0,2,32'h24,32'h24,1,1,0,1));
    push("ovf_back_idle",    s(1,0,0,0,0,0,0,0,0),           o(0,0,0,0,V,32'h24,1,0,0,1));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      e = eq.pop_front(); n = nq.pop_front(); checks++;
      if (obs !== e) $display("FAIL %s: got %h expected %h", n, obs, e);
      else passes++;
    end
  endtask

  task automatic test_undef;
    obs_t e; string n;
    push("u2_stalled",   s(1,0,0,0,1,0,1,0,32'h10), o(0,0,0,0,V,32'h24,1,0,0,1));
    push("eret_in_idle", s(1,0,0,0,0,1,0,0,0),      o(0,0,0,0,V,32'h24,1,0,0,1));
    push("u2_enter",     s(1,0,0,0,1,0,0,0,32'h10), o(1,1,0,1,V,32'h24,1,0,0,1));
    push("u2_handler",   s(1,0,0,0,0,0,0,0,0),      o(0,0,0,0,V,32'h10,3,1,0,2));
    push("u2_eret",      s(1,0,0,0,0,1,0,0,0),      o(1,0,0,2,32'h10,32'h10,3,1,0,2));
    push("u1u2_enter",   s(1,0,0,1,1,0,0,0,32'h20), o(1,1,0,1,V,32'h10,3,0,0,2));
    push("u1_handler",   s(1,0,0,0,0,0,0,0,0),      o(0,0,0,0,V,32'h20,2,1,0,3));
    push("u1_eret",      s(1,0,0,0,0,1,0,0,0),      o(1,0,0,2,32'h20,32'h20,2,1,0,3));
    push("u1_back_idle", s(1,0,0,0,0,0,0,0,0),      o(0,0,0,0,V,32'h20,2,0,0,3));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      e = eq.pop_front(); n = nq.pop_front(); checks++;
      if (obs !== e) $display("FAIL %s: got %h expected %h", n, obs, e);
      else passes++;
    end
  endtask

  task automatic test_double_fault;
    obs_t e; string n;
    push("df_reset",     s(0,0,0,0,0,0,0,0,0),       o(0,0,0,0,V,0,0,0,0,0));
    push("df_enter",     s(1,0,0,0,1,0,0,0,32'h10),  o(1,1,0,1,V,0,0,0,0,0));
    push("df_fault",     s(1,0,1,0,0,1,0,32'h50,0),  o(1,1,1,3,V,32'h10,3,1,0,1));
    push("df_halted",    s(1,0,0,0,0,0,0,0,0),       o(1,1,1,3,V,32'h10,1,0,1,2));
    push("df_halt_eret", s(1,0,0,0,0,1,0,0,0),       o(1,1,1,3,V,32'h10,1,0,1,2));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      e = eq.pop_front(); n = nq.pop_front(); checks++;
      if (obs !== e) $display("FAIL %s: got %h expected %h", n, obs, e);
      else passes++;
    end
  endtask

  task automatic test_watchdog;
    obs_t e; string n;
    push("wd_reset", s(0,0,0,0,0,0,0,0,0),      o(0,0,0,0,V,0,0,0,0,0));
    push("wd_enter", s(1,1,0,0,0,0,0,32'h30,0), o(1,1,1,1,V,0,0,0,0,0));
    for (int k = 0; k < 4; k++)
      push("wd_wait", s(1,0,0,0,0,0,0,0,0),     o(0,0,0,0,V,32'h30,1,1,0,1));
    push("wd_fire",    s(1,0,0,0,0,0,0,0,0),    o(1,1,1,3,V,32'h30,1,1,0,1));
    push("wd_halted",  s(1,0,0,0,0,0,0,0,0),    o(1,1,1,3,V,32'h30,0,0,1,1));
    push("wd_reset2",  s(0,0,0,0,0,0,0,0,0),    o(0,0,0,0,V,0,0,0,0,0));
    push("wd_enter2",  s(1,1,0,0,0,0,0,32'h34,0), o(1,1,1,1,V,0,0,0,0,0));
    for (int k = 0; k < 4; k++)
      push("wd_wait2", s(1,0,0,0,0,0,0,0,0),    o(0,0,0,0,V,32'h34,1,1,0,1));
    push("wd_eret_wins", s(1,0,0,0,0,1,0,0,0),  o(1,0,0,2,32'h34,32'h34,1,1,0,1));
    push("wd_idle",      s(1,0,0,0,0,0,0,0,0),  o(0,0,0,0,V,32'h34,1,0,0,1));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      e = eq.pop_front(); n = nq.pop_front(); checks++;
      if (obs !== e) $display("FAIL %s: got %h expected %h", n, obs, e);
      else passes++;
    end
  endtask

  // Exception immediately after each ERET return; counter saturates at 3.
  task automatic test_back_to_back;
    obs_t e; string n;
    logic [31:0] pc, pe;
    logic [1:0]  cprev, cnew, cause_prev;
    push("b2b_reset", s(0,0,0,0,0,0,0,0,0), o(0,0,0,0,V,0,0,0,0,0));
    for (int i = 0; i < 4; i++) begin
      pc         = 32'h100 + i;
      pe         = (i == 0) ? 32'h0 : 32'h100 + i - 1;
      cprev      = (i < 3) ? 2'(i) : 2'd3;
      cnew       = (i + 1 < 3) ? 2'(i + 1) : 2'd3;
      cause_prev = (i == 0) ? 2'd0 : 2'd1;
      push("b2b_enter", s(1,1,0,0,0,0,0,pc,0), o(1,1,1,1,V,pe,cause_prev,0,0,cprev));
      push("b2b_eret",  s(1,0,0,0,0,1,0,0,0),  o(1,0,0,2,pc,pc,1,1,0,cnew));
    end
    push("b2b_idle", s(1,0,0,0,0,0,0,0,0), o(0,0,0,0,V,32'h103,1,0,0,3));
    while (sq.size() > 0) begin
      apply(sq.pop_front());
      e = eq.pop_front(); n = nq.pop_front(); checks++;
      if (obs !== e) $display("FAIL %s: got %h expected %h", n, obs, e);
      else passes++;
    end
  endtask

  initial begin
    test_reset;
    test_ovf;
    test_undef;
    test_double_fault;
    test_watchdog;
    test_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
